uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of byte requesters, range 2..16.
REQ-002 Parameter MAX_BURST, default 4: maximum bytes one requester sends per grant, range 1..255.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_data  input  8*N_REQ  byte from requester i on bits [8i+7:8i].
REQ-006 req_valid  input  N_REQ  requester i has a byte pending.
REQ-007 req_ready  output  N_REQ  requester i's byte is accepted this cycle.
REQ-008 tx_data  output  8  byte to the shared UART transmitter.
REQ-009 tx_data_valid  output  1  tx_data is valid and held until accepted.
REQ-010 tx_data_ready  input  1  transmitter accepts tx_data this cycle.
REQ-011 grant_id  output  clog2(N_REQ)  index of the current or last granted requester.
REQ-012 busy  output  1  high while in the SEND state.

Function
REQ-013 A handshake occurs when valid and ready are both high on the same rising edge, on both sides.
REQ-014 The FSM has two states: IDLE and SEND.
REQ-015 IDLE, no req_valid bit set: stay in IDLE; req_ready = 0; tx_data_valid = 0.
REQ-016 IDLE, one or more req_valid bits set: select winner g.
- g is the first set bit searching upward from (last_grant+1) mod N_REQ, with wrap-around.
- Assert req_ready[g] combinationally in the same cycle.
- On the edge: latch req_data[g] into the holding register; set last_grant = g, grant_id = g, burst_cnt = 1; go to SEND.
REQ-017 Latency: a byte accepted in IDLE in cycle T appears with tx_data_valid = 1 in cycle T+1.
REQ-018 SEND: tx_data_valid = 1 and tx_data = holding register.
- tx_data and tx_data_valid stay stable until tx_data_ready is high.
- busy = 1.
REQ-019 SEND, tx_data_ready = 1, req_valid[g] = 1 and burst_cnt < MAX_BURST:
- Assert req_ready[g] combinationally.
- Latch req_data[g] and increment burst_cnt.
- Stay in SEND, so back-to-back bytes flow with no bubble.
REQ-020 SEND, tx_data_ready = 1, and either req_valid[g] = 0 or burst_cnt = MAX_BURST: req_ready all 0; go to IDLE.
REQ-021 SEND, tx_data_ready = 0: req_ready all 0; no state change.
REQ-022 At most one req_ready bit is high in any cycle, and only for a requester whose req_valid is high.
REQ-023 Fairness: after a grant to g ends, a continuously requesting requester k is granted within N_REQ-1 further grants.
REQ-024 Requesters that are not granted see req_ready = 0 and must hold their data; the arbiter never drops or duplicates a byte.
REQ-025 req_valid deasserted by a non-granted requester has no effect. Deassertion by g while in SEND only ends the burst per REQ-020.
REQ-026 grant_id holds its last value in IDLE.
REQ-027 busy = 0 in IDLE.
REQ-028 burst_cnt is 8 bits and saturates, with no wrap; MAX_BURST = 1 gives one byte per grant.
REQ-029 The outputs req_ready, busy and tx_data_valid are derived only from state, req_valid, tx_data_ready and internal registers; no combinational path exists from req_data to any control output.

Reset
REQ-030 With rst high on an edge, the block enters IDLE.
- tx_data = 0, tx_data_valid = 0, grant_id = 0, busy = 0, burst_cnt = 0.
- last_grant = N_REQ-1, so the first search starts at index 0.
REQ-031 While rst is high, req_ready = 0 regardless of inputs.
REQ-032 rst asserted mid-SEND abandons the held byte; tx_data_valid is low from the next cycle.
REQ-033 The first arbitration can occur in the first cycle with rst low.

Verification
REQ-034 Single requester: N_REQ=4, MAX_BURST=4; req 2 sends 0xA5, tx_data_ready tied 1 -> req_ready[2] in cycle T; tx_data=0xA5 with valid in T+1; grant_id=2; IDLE in T+2.
REQ-035 Round robin: all four requesters valid, MAX_BURST=1 -> grant order 0,1,2,3,0, each byte transmitted exactly once and in order.
REQ-036 Burst limit: req 1 streams 0x10..0x15 with MAX_BURST=4 and req 3 also valid -> 0x10..0x13 sent back-to-back, then one byte from req 3, then 0x14.
REQ-037 Backpressure: tx_data_ready low for 20 cycles during SEND -> tx_data and tx_data_valid stable, all req_ready = 0; resumes on ready.
REQ-038 Reset mid-SEND -> next cycle tx_data_valid=0, busy=0, grant_id=0; the next arbitration starts at index 0.
REQ-039 Random stimulus on a uart_tx/uart_rx loopback -> the received byte stream per requester equals the sent stream, with one-hot-or-zero req_ready checked every cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels bytes from N_REQ requesters into one UART transmitter,
// using a single holding register and bounded per-grant bursts.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IdW      = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [IdW-1:0]       grant_id,
    output logic                 busy
);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    localparam logic [IdW-1:0] LastIdx  = IdW'(N_REQ - 1);
    localparam logic [7:0]     BurstMax = 8'(MAX_BURST);
    localparam logic [IdW:0]   NumReq   = (IdW + 1)'(N_REQ);

    state_e         state_q, state_d;
    logic [7:0]     hold_q, hold_d;
    logic [IdW-1:0] last_grant_q, last_grant_d;
    logic [IdW-1:0] grant_id_q, grant_id_d;
    logic [7:0]     burst_cnt_q, burst_cnt_d;

    logic           found;
    logic [IdW-1:0] winner;
    logic [IdW:0]   cand;

    // Search upward from last_grant+1 with wrap; only req_valid feeds the decision.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 1; off <= int'(N_REQ); off++) begin
            cand = {1'b0, last_grant_q} + (IdW + 1)'(off);
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!found && req_valid[cand[IdW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IdW-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        burst_cnt_d   = burst_cnt_q;
        req_ready     = '0;
        tx_data_valid = 1'b0;
        busy          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    hold_d            = req_data[{winner, 3'b000} +: 8];
                    last_grant_d      = winner;
                    grant_id_d        = winner;
                    burst_cnt_d       = 8'd1;
                    state_d           = StSend;
                end
            end
            StSend: begin
                tx_data_valid = 1'b1;
                busy          = 1'b1;
                if (tx_data_ready) begin
                    if (req_valid[last_grant_q] && (burst_cnt_q < BurstMax)) begin
                        // Refill the holding register on the same edge it drains: no bubble.
                        req_ready[last_grant_q] = 1'b1;
                        hold_d                  = req_data[{last_grant_q, 3'b000} +: 8];
                        if (burst_cnt_q != 8'hFF) begin
                            burst_cnt_d = burst_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            hold_q       <= 8'h00;
            last_grant_q <= LastIdx;
            grant_id_q   <= '0;
            burst_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign tx_data  = hold_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a cycle table on a MAX_BURST=4 instance, then scoreboarded
// streams (round robin on a MAX_BURST=1 instance, burst limit, random traffic).
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic        tx_ready;

    logic [3:0] rdy_a, rdy_b;
    logic [7:0] txd_a, txd_b;
    logic       txv_a, txv_b;
    logic [1:0] gid_a, gid_b;
    logic       busy_a, busy_b;

    uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(4)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_ready     (rdy_a),
        .tx_data       (txd_a),
        .tx_data_valid (txv_a),
        .tx_data_ready (tx_ready),
        .grant_id      (gid_a),
        .busy          (busy_a)
    );

    uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(1)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_ready     (rdy_b),
        .tx_data       (txd_b),
        .tx_data_valid (txv_b),
        .tx_data_ready (tx_ready),
        .grant_id      (gid_b),
        .busy          (busy_b)
    );

    // Stream phases observe one instance at a time.
    logic       sel;
    logic [3:0] m_rdy;
    logic [7:0] m_txd;
    logic       m_txv;
    logic [1:0] m_gid;
    assign m_rdy = sel ? rdy_b : rdy_a;
    assign m_txd = sel ? txd_b : txd_a;
    assign m_txv = sel ? txv_b : txv_a;
    assign m_gid = sel ? gid_b : gid_a;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        tx_ready;
        logic [3:0]  e_rdy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        dchk;
        logic [1:0]  e_gid;
        logic        e_busy;
    } vec_t;

    localparam logic [31:0] D0 = 32'h77A5_3311;
    localparam logic [31:0] D1 = 32'h77A5_3322;

    vec_t vt [15];

    // Stream model state
    int         k_cnt [4];
    int         lim   [4];
    logic [7:0] base  [4];
    logic [7:0] rxq   [4][$];
    int         order_q[$];
    int         hs_cyc[$];

    task automatic run_stream(input logic s, input bit rnd, input int stall_at, input int max_cyc);
        int         cyc;
        bit         done;
        bit         last_stall;
        logic [7:0] last_txd;
        logic [3:0] acc;
        logic [7:0] b;
        int         id;
        cyc        = 0;
        done       = 1'b0;
        last_stall = 1'b0;
        last_txd   = 8'h00;
        sel        = s;
        hs_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            k_cnt[i] = 0;
            rxq[i].delete();
        end
        rst       = 1'b1;
        req_valid = 4'b0;
        tx_ready  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        while (!done && cyc < max_cyc) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && k_cnt[i] < lim[i] && (!rnd || $urandom_range(0, 2) != 0)) begin
                    b = base[i] + 8'(k_cnt[i]);
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = b;
                    rxq[i].push_back(b);
                end
            end
            if (rnd) tx_ready = ($urandom_range(0, 3) != 0);
            else     tx_ready = !(cyc >= stall_at && cyc < stall_at + 20);
            #1;
            chk("rdy_onehot0", 32'($onehot0(m_rdy)), 32'd1);
            chk("rdy_only_valid", 32'(m_rdy & ~req_valid), 32'd0);
            if (last_stall) begin
                chk("stall_hold_valid", 32'(m_txv), 32'd1);
                chk("stall_hold_data", 32'(m_txd), 32'(last_txd));
            end
            if (m_txv && !tx_ready) chk("stall_rdy_zero", 32'(m_rdy), 32'd0);
            last_stall = m_txv && !tx_ready;
            last_txd   = m_txd;
            acc        = m_rdy & req_valid;
            if (m_txv && tx_ready) begin
                id = int'(m_gid);
                if (rxq[id].size() == 0) begin
                    chk("rx_unexpected_byte", 32'(m_txd), 32'hFFFF_FFFF);
                end else begin
                    chk("rx_data", 32'(m_txd), 32'(rxq[id].pop_front()));
                end
                if (order_q.size() > 0) chk("grant_order", 32'(m_gid), 32'(order_q.pop_front()));
                hs_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                    k_cnt[i]++;
                end
            end
            done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (k_cnt[i] < lim[i] || rxq[i].size() != 0) done = 1'b0;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_timeout: not drained after %0d cycles", max_cyc);
        end
        chk("order_drained", 32'(order_q.size()), 32'd0);
        req_valid = 4'b0;
    endtask

    initial begin
        vt[0]  = '{1'b1, 4'b1111, D0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
        vt[1]  = '{1'b0, 4'b0100, D0, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
        vt[2]  = '{1'b0, 4'b0000, D0, 1'b1, 4'b0000, 1'b1, 8'hA5, 1'b1, 2'd2, 1'b1};
        vt[3]  = '{1'b0, 4'b0000, D0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0};
        vt[4]  = '{1'b0, 4'b0001, D0, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0};
        vt[5]  = '{1'b0, 4'b0011, D0, 1'b0, 4'b0000, 1'b1, 8'h11, 1'b1, 2'd0, 1'b1};
        vt[6]  = '{1'b0, 4'b0011, D0, 1'b0, 4'b0000, 1'b1, 8'h11, 1'b1, 2'd0, 1'b1};
        vt[7]  = '{1'b0, 4'b0011, D1, 1'b1, 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0, 1'b1};
        vt[8]  = '{1'b0, 4'b0010, D1, 1'b1, 4'b0000, 1'b1, 8'h22, 1'b1, 2'd0, 1'b1};
        vt[9]  = '{1'b0, 4'b0010, D1, 1'b1, 4'b0010, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        vt[10] = '{1'b0, 4'b0000, D1, 1'b1, 4'b0000, 1'b1, 8'h33, 1'b1, 2'd1, 1'b1};
        vt[11] = '{1'b0, 4'b1000, D1, 1'b1, 4'b1000, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
        vt[12] = '{1'b1, 4'b1000, D1, 1'b0, 4'b0000, 1'b1, 8'h77, 1'b1, 2'd3, 1'b1};
        vt[13] = '{1'b0, 4'b1010, D1, 1'b0, 4'b0010, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
        vt[14] = '{1'b0, 4'b0000, D1, 1'b1, 4'b0000, 1'b1, 8'h33, 1'b1, 2'd1, 1'b1};

        sel       = 1'b0;
        rst       = 1'b1;
        req_valid = 4'b0;
        req_data  = 32'h0;
        tx_ready  = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            rst       = vt[i].rst;
            req_valid = vt[i].valid;
            req_data  = vt[i].data;
            tx_ready  = vt[i].tx_ready;
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(rdy_a), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d_tx_valid", i), 32'(txv_a), 32'(vt[i].e_txv));
            chk($sformatf("v%0d_grant_id", i), 32'(gid_a), 32'(vt[i].e_gid));
            chk($sformatf("v%0d_busy", i), 32'(busy_a), 32'(vt[i].e_busy));
            if (vt[i].dchk) chk($sformatf("v%0d_tx_data", i), 32'(txd_a), 32'(vt[i].e_txd));
            @(posedge clk);
            #1;
        end

        // Round robin, one byte per grant, with a 20-cycle stall on the first byte.
        for (int i = 0; i < 4; i++) begin
            lim[i]  = 2;
            base[i] = 8'(i * 16);
        end
        order_q.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) order_q.push_back(i);
        end
        run_stream(1'b1, 1'b0, 1, 200);

        // Burst limit: req 1 streams 0x10..0x15, req 3 offers one byte.
        lim  = '{0, 6, 0, 1};
        base = '{8'h00, 8'h10, 8'h00, 8'hC0};
        order_q.delete();
        order_q = '{1, 1, 1, 1, 3, 1, 1};
        run_stream(1'b0, 1'b0, 1000, 200);
        if (hs_cyc.size() >= 4) begin
            for (int j = 1; j < 4; j++) chk($sformatf("burst_no_bubble_%0d", j),
                                            32'(hs_cyc[j] - hs_cyc[j-1]), 32'd1);
        end else begin
            chk("burst_handshakes", 32'(hs_cyc.size()), 32'd7);
        end

        // Random traffic and backpressure, per-requester stream check.
        for (int i = 0; i < 4; i++) begin
            lim[i]  = 30;
            base[i] = 8'(i * 64);
        end
        order_q.delete();
        run_stream(1'b0, 1'b1, 0, 3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
